prime_gen: RTL and testbench

PRIME_GEN -- requirements
Module: prime_gen

---
 rtl/prime_pkg.sv | 9 +
 rtl/prime_chk.sv | 12 +
 rtl/prime_gen.sv | 85 ++++++++
 tb/tb_prime_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// prime_pkg: shared state encoding and sequence limits for the prime generator.
package prime_pkg;

    typedef enum logic [1:0] {IDLE, SEARCH, HOLD, DONE} state_t;

    localparam logic [3:0] LAST_CAND  = 4'd15;
    localparam logic [2:0] NUM_PRIMES = 3'd6;

endpackage

// File: rtl/prime_chk.sv
// prime_chk: combinational 4-bit primality test.
module prime_chk (
    input  logic [3:0] cand_i,
    output logic       is_prime_o
);

    // one bit per value 0..15, set for 2,3,5,7,11,13
    localparam logic [15:0] PRIME_MASK = 16'h28AC;

    assign is_prime_o = PRIME_MASK[cand_i];

endmodule

// File: rtl/prime_gen.sv
// prime_gen: steps a 4-bit candidate, presents each prime with a valid/ready handshake.
module prime_gen
    import prime_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ready,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic [2:0] count
);

    state_t     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] val_q, val_d;
    logic [2:0] count_q, count_d;
    logic       is_prime;

    prime_chk u_chk (
        .cand_i    (cand_q),
        .is_prime_o(is_prime)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= 4'd0;
            val_q   <= 4'd0;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            val_q   <= val_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? SEARCH : state_q;
            SEARCH:     state_d = is_prime ? HOLD :
                                  (cand_q == LAST_CAND && !WRAP) ? DONE : SEARCH;
            HOLD:       state_d = ready ? SEARCH : HOLD;
        endcase
    end

    // candidate counter and output register are kept apart so A..D stay quiet while searching
    always_comb begin
        cand_d  = cand_q;
        val_d   = val_q;
        count_d = count_q;
        case (state_q)
            IDLE, DONE: begin
                cand_d  = start ? 4'd0 : cand_q;
                count_d = start ? 3'd0 : count_q;
            end
            SEARCH: begin
                cand_d = is_prime ? cand_q : cand_q + 4'd1;
                val_d  = is_prime ? cand_q : val_q;
            end
            HOLD: begin
                cand_d  = ready ? cand_q + 4'd1 : cand_q;
                count_d = (ready && count_q != NUM_PRIMES) ? count_q + 3'd1 : count_q;
            end
        endcase
    end

    always_comb begin
        valid = state_q == HOLD;
        busy  = state_q == SEARCH || state_q == HOLD;
        done  = state_q == DONE;
        {A, B, C, D} = val_q;
        count = count_q;
    end

endmodule

// File: tb/tb_prime_gen.sv
// tb_prime_gen: table-driven and randomized checks of prime_gen with WRAP=0 and WRAP=1 side by side.
module tb_prime_gen;

    logic clk = 1'b0;
    logic rst, start, ready;
    logic a0, b0, c0, d0, v0, bs0, dn0;
    logic a1, b1, c1, d1, v1, bs1, dn1;
    logic [2:0] ct0, ct1;

    prime_gen #(.WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .A(a0), .B(b0), .C(c0), .D(d0),
        .valid(v0), .busy(bs0), .done(dn0), .count(ct0)
    );

    prime_gen #(.WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .A(a1), .B(b1), .C(c1), .D(d1),
        .valid(v1), .busy(bs1), .done(dn1), .count(ct1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // reference: phase 0 idle, 1 working toward nxt, 2 presenting nxt, 3 done; wt = edges left
    int ph[2], nxt[2], wt[2], cnt[2];

    typedef struct {
        logic       s;
        logic       r;
        logic       v;
        logic [3:0] val;
        logic       b;
        logic       d;
        logic [2:0] c;
    } vec_t;

    vec_t tbl[24];

    function automatic bit is_p(int v);
        if (v < 2) return 1'b0;
        for (int i = 2; i < v; i++)
            if (v % i == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int next_prime(int p);
        for (int i = p + 1; i < 16; i++)
            if (is_p(i)) return i;
        return 0;
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            ph[w] = 0; nxt[w] = 0; wt[w] = 0; cnt[w] = 0;
        end
    endtask

    task automatic model_step(input int w, input logic s, input logic r);
        int cur;
        case (ph[w])
            0, 3: if (s) begin ph[w] = 1; nxt[w] = 2; wt[w] = 3; cnt[w] = 0; end
            1: begin
                wt[w]--;
                if (wt[w] == 0) ph[w] = (nxt[w] == 0) ? 3 : 2;
            end
            2: if (r) begin
                cnt[w] = (cnt[w] < 6) ? cnt[w] + 1 : 6;
                cur = nxt[w];
                nxt[w] = next_prime(cur);
                if (nxt[w] == 0 && w == 1) begin nxt[w] = 2; wt[w] = 16 - cur + 2; end
                else if (nxt[w] == 0) wt[w] = 15 - cur;
                else wt[w] = nxt[w] - cur;
                ph[w] = 1;
            end
            default: ;
        endcase
    endtask

    task automatic check_dut(input int w, input logic [3:0] v, input logic vl,
                             input logic bs, input logic dn, input logic [2:0] ct);
        string p;
        p = $sformatf("w%0d_", w);
        chk({p, "valid"}, int'(vl), int'(ph[w] == 2));
        if (ph[w] == 2) chk({p, "value"}, int'(v), nxt[w]);
        if (vl) chk({p, "is_prime"}, int'(is_p(int'(v))), 1);
        chk({p, "busy"}, int'(bs), int'(ph[w] == 1 || ph[w] == 2));
        chk({p, "done"}, int'(dn), int'(ph[w] == 3));
        chk({p, "count"}, int'(ct), cnt[w]);
    endtask

    task automatic tick(input logic s, input logic r);
        start = s;
        ready = r;
        @(posedge clk);
        model_step(0, s, r);
        model_step(1, s, r);
        @(negedge clk);
        check_dut(0, {a0, b0, c0, d0}, v0, bs0, dn0, ct0);
        check_dut(1, {a1, b1, c1, d1}, v1, bs1, dn1, ct1);
    endtask

    task automatic run_until(input int w, input int p);
        for (int k = 0; k < 60 && !(ph[w] == 2 && nxt[w] == p); k++) tick(1'b0, 1'b1);
        chk($sformatf("reach_w%0d_%0d", w, p), int'(ph[w] == 2 && nxt[w] == p), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        tbl[0]  = '{1, 1, 0, 0, 1, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 1, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 1, 1, 2, 1, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 1, 0, 1};
        tbl[5]  = '{0, 1, 1, 3, 1, 0, 1};
        tbl[6]  = '{0, 1, 0, 0, 1, 0, 2};
        tbl[7]  = '{0, 1, 0, 0, 1, 0, 2};
        tbl[8]  = '{0, 1, 1, 5, 1, 0, 2};
        tbl[9]  = '{0, 1, 0, 0, 1, 0, 3};
        tbl[10] = '{0, 1, 0, 0, 1, 0, 3};
        tbl[11] = '{0, 1, 1, 7, 1, 0, 3};
        tbl[12] = '{0, 1, 0, 0, 1, 0, 4};
        tbl[13] = '{0, 1, 0, 0, 1, 0, 4};
        tbl[14] = '{0, 1, 0, 0, 1, 0, 4};
        tbl[15] = '{0, 1, 0, 0, 1, 0, 4};
        tbl[16] = '{0, 1, 1, 11, 1, 0, 4};
        tbl[17] = '{0, 1, 0, 0, 1, 0, 5};
        tbl[18] = '{0, 1, 0, 0, 1, 0, 5};
        tbl[19] = '{0, 1, 1, 13, 1, 0, 5};
        tbl[20] = '{0, 1, 0, 0, 1, 0, 6};
        tbl[21] = '{0, 1, 0, 0, 1, 0, 6};
        tbl[22] = '{0, 0, 0, 0, 0, 1, 6};
        tbl[23] = '{0, 0, 0, 0, 0, 1, 6};

        rst = 1'b1; start = 1'b0; ready = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_outs0", int'({a0, b0, c0, d0, v0, bs0, dn0, ct0}), 0);
        chk("rst_outs1", int'({a1, b1, c1, d1, v1, bs1, dn1, ct1}), 0);
        rst = 1'b0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);

        // full WRAP=0 sequence, cycle by cycle
        for (int i = 0; i < 24; i++) begin
            tick(tbl[i].s, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), int'(v0), int'(tbl[i].v));
            if (tbl[i].v) chk($sformatf("tbl%0d_value", i), int'({a0, b0, c0, d0}), int'(tbl[i].val));
            chk($sformatf("tbl%0d_busy", i), int'(bs0), int'(tbl[i].b));
            chk($sformatf("tbl%0d_done", i), int'(dn0), int'(tbl[i].d));
            chk($sformatf("tbl%0d_count", i), int'(ct0), int'(tbl[i].c));
        end

        // start in DONE restarts; stall on 5 with start pulsed during HOLD
        tick(1'b1, 1'b1);
        run_until(0, 5);
        for (int i = 0; i < 5; i++) begin
            tick(i == 2, 1'b0);
            chk("stall_value", int'({a0, b0, c0, d0}), 5);
            chk("stall_valid", int'(v0), 1);
        end
        tick(1'b0, 1'b1);
        chk("after_stall_count", int'(ct0), 3);
        run_until(0, 7);

        for (int i = 0; i < 300; i++) tick(($urandom % 16) == 0, 1'($urandom % 2));

        // reset mid-HOLD while presenting 11
        for (int k = 0; k < 60 && ph[0] != 3 && ph[0] != 0; k++) tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        run_until(0, 11);
        tick(1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("rst_hold_outs0", int'({a0, b0, c0, d0, v0, bs0, dn0, ct0}), 0);
        chk("rst_hold_outs1", int'({a1, b1, c1, d1, v1, bs1, dn1, ct1}), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        run_until(0, 2);
        chk("restart_value", int'({a0, b0, c0, d0}), 2);
        chk("restart_count", int'(ct0), 0);

        // WRAP=1: after 13, 2 again after 5 edges, count saturates, never done
        for (int j = 0; j < 2; j++) begin
            run_until(1, 13);
            tick(1'b0, 1'b1);
            n = 0;
            while (!v1 && n < 20) begin
                tick(1'b0, 1'b1);
                n++;
            end
            chk("wrap_gap", n, 5);
            chk("wrap_value", int'({a1, b1, c1, d1}), 2);
            chk("wrap_count", int'(ct1), 6);
            chk("wrap_done", int'(dn1), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
